// File: rtl/button_pkg.sv
// Shared constants and types for the button event path.
package button_pkg;
  localparam int   BTN_N      = 4;
  localparam int   CODE_W     = 2;
  localparam logic RST_ACTIVE = 1'b0;

  typedef logic [CODE_W-1:0] btn_code_t;
endpackage

// File: rtl/button_event_fifo.sv
// DEPTH-entry event FIFO for button codes; occupancy derives from the
// registered pointers, which carry one extra wrap bit.
module button_event_fifo
  import button_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  btn_code_t     code_i,
  input  logic          pop_i,
  output btn_code_t     head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);
  btn_code_t       mem_q [DEPTH];
  logic [AW:0]     wptr_q, rptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (rst_ni == RST_ACTIVE) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      // At full with a pop, the write lands in the slot being vacated.
      if (push_i) begin
        mem_q[wptr_q[AW-1:0]] <= code_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop_i) rptr_q <= rptr_q + 1'b1;
    end
  end

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (count_o == '0);
  assign head_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
endmodule

// File: rtl/button_event_scheduler.sv
// Pending-request register, round-robin arbiter and saturating drop counter
// feeding granted button codes into the event FIFO.
module button_event_scheduler
  import button_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [BTN_N-1:0]         press_pulse_i,
  input  logic                     flush_i,
  output logic                     evt_valid_o,
  output btn_code_t                evt_code_o,
  input  logic                     evt_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [DROP_W-1:0]        drop_count_o
);
  logic [BTN_N-1:0]  pending_q, pending_d;
  btn_code_t         rr_q, rr_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              pop, grant_vld;
  btn_code_t         grant, idx;
  logic [BTN_N-1:0]  gmask, coalesce;

  assign evt_valid_o = ~empty_o;
  assign pop         = evt_valid_o & evt_ready_i & ~flush_i;

  always_comb begin
    grant_vld = 1'b0;
    grant     = rr_q;
    idx       = rr_q;
    for (int k = 0; k < BTN_N; k++) begin
      idx = rr_q + btn_code_t'(k);
      if (!grant_vld && pending_q[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
    // Backpressure: no grant while full unless the head leaves this cycle.
    grant_vld = grant_vld & (~full_o | pop) & ~flush_i;

    gmask = '0;
    if (grant_vld) gmask[grant] = 1'b1;
    coalesce = press_pulse_i & pending_q & ~gmask;

    drop_d = drop_q;
    if (!flush_i) begin
      for (int i = 0; i < BTN_N; i++)
        if (coalesce[i] && drop_d != '1) drop_d = drop_d + 1'b1;
    end

    if (flush_i) begin
      pending_d = '0;
      rr_d      = '0;
    end else begin
      pending_d = (pending_q & ~gmask) | press_pulse_i;
      rr_d      = grant_vld ? grant + 1'b1 : rr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (rst_ni == RST_ACTIVE) begin
      pending_q <= '0;
      rr_q      <= '0;
      drop_q    <= '0;
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
      drop_q    <= drop_d;
    end
  end

  assign drop_count_o = drop_q;

  button_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (grant_vld),
    .code_i  (grant),
    .pop_i   (pop),
    .head_o  (evt_code_o),
    .count_o (count_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );
endmodule
